// File: rtl/mips_isa_pkg.sv
// MIPS subset ISA constants: request selector, opcodes, funct codes and
// field-packing helpers shared by the instruction encoder.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    SelAdd  = 5'd0,  SelSub  = 5'd1,  SelAnd  = 5'd2,  SelOr   = 5'd3,
    SelSlt  = 5'd4,  SelSltu = 5'd5,  SelAddu = 5'd6,  SelSubu = 5'd7,
    SelSll  = 5'd8,  SelNor  = 5'd9,  SelSrl  = 5'd10, SelSllv = 5'd11,
    SelSrlv = 5'd12, SelJr   = 5'd13, SelJalr = 5'd14, SelAddi = 5'd15,
    SelOri  = 5'd16, SelLw   = 5'd17, SelSw   = 5'd18, SelBeq  = 5'd19,
    SelLui  = 5'd20, SelSlti = 5'd21, SelBne  = 5'd22, SelAndi = 5'd23,
    SelJ    = 5'd24, SelJal  = 5'd25
  } instr_sel_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;

  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {OpRtype, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational mapping from an instruction request to its 32-bit word.
// Fields an instruction does not use are forced to zero.
module mips_instr_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (sel)
      SelAdd:  word = enc_r(rs, rt, rd, 5'd0, FnAdd);
      SelSub:  word = enc_r(rs, rt, rd, 5'd0, FnSub);
      SelAnd:  word = enc_r(rs, rt, rd, 5'd0, FnAnd);
      SelOr:   word = enc_r(rs, rt, rd, 5'd0, FnOr);
      SelSlt:  word = enc_r(rs, rt, rd, 5'd0, FnSlt);
      SelSltu: word = enc_r(rs, rt, rd, 5'd0, FnSltu);
      SelAddu: word = enc_r(rs, rt, rd, 5'd0, FnAddu);
      SelSubu: word = enc_r(rs, rt, rd, 5'd0, FnSubu);
      SelSll:  word = enc_r(5'd0, rt, rd, shamt, FnSll);
      SelNor:  word = enc_r(rs, rt, rd, 5'd0, FnNor);
      SelSrl:  word = enc_r(5'd0, rt, rd, shamt, FnSrl);
      SelSllv: word = enc_r(rs, rt, rd, 5'd0, FnSllv);
      SelSrlv: word = enc_r(rs, rt, rd, 5'd0, FnSrlv);
      SelJr:   word = enc_r(rs, 5'd0, 5'd0, 5'd0, FnJr);
      SelJalr: word = enc_r(rs, 5'd0, rd, 5'd0, FnJalr);
      SelAddi: word = enc_i(OpAddi, rs, rt, imm);
      SelOri:  word = enc_i(OpOri, rs, rt, imm);
      SelLw:   word = enc_i(OpLw, rs, rt, imm);
      SelSw:   word = enc_i(OpSw, rs, rt, imm);
      SelBeq:  word = enc_i(OpBeq, rs, rt, imm);
      SelLui:  word = enc_i(OpLui, 5'd0, rt, imm);
      SelSlti: word = enc_i(OpSlti, rs, rt, imm);
      SelBne:  word = enc_i(OpBne, rs, rt, imm);
      SelAndi: word = enc_i(OpAndi, rs, rt, imm);
      SelJ:    word = {OpJ, target};
      SelJal:  word = {OpJal, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streams encoded MIPS instructions into instruction memory starting at a
// latched base address, one registered write per legal request.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_sel,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] DepthCnt = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CntOne   = 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_inc;
  logic              err_illegal_q, err_overflow_q;
  logic              im_we_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [31:0]       im_wdata_q;
  logic [31:0]       word;
  logic              illegal;
  logic              accept;
  logic              start_load;
  logic              fills_mem;

  mips_instr_pack u_pack (
    .sel     (in_sel),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .target  (in_target),
    .word    (word),
    .illegal (illegal)
  );

  assign accept     = in_valid && (state_q == StRun);
  assign start_load = start && (state_q != StRun);
  assign count_inc  = count_q + CntOne;
  assign fills_mem  = !illegal && (count_inc == DepthCnt);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (accept && (in_last || fills_mem)) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StIdle;
      base_q         <= '0;
      count_q        <= '0;
      err_illegal_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      im_we_q        <= 1'b0;
      im_addr_q      <= '0;
      im_wdata_q     <= '0;
    end else begin
      state_q <= state_d;
      im_we_q <= accept && !illegal;
      if (start_load) begin
        base_q         <= base_addr;
        count_q        <= '0;
        err_illegal_q  <= 1'b0;
        err_overflow_q <= 1'b0;
      end
      if (accept) begin
        if (illegal) begin
          err_illegal_q <= 1'b1;
        end else begin
          count_q    <= count_inc;
          // Truncation to ADDR_W bits gives the wrap at the top of IM.
          im_addr_q  <= base_q + count_q[ADDR_W-1:0];
          im_wdata_q <= word;
          if (!in_last && fills_mem) err_overflow_q <= 1'b1;
        end
      end
    end
  end

  assign in_ready     = (state_q == StRun);
  assign busy         = (state_q == StRun);
  assign done         = (state_q == StDone);
  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign err_illegal  = err_illegal_q;
  assign err_overflow = err_overflow_q;
  assign word_count   = count_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench: a full-size encoder (ADDR_W=8) and a 4-word one (ADDR_W=2)
// driven by the same request stream.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  base_a;
  logic [1:0]  base_b;
  logic        in_valid;
  logic [4:0]  in_sel, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;

  logic        rdy_a, we_a, busy_a, done_a, eill_a, eovf_a;
  logic [7:0]  addr_a;
  logic [31:0] data_a;
  logic [8:0]  cnt_a;
  logic        rdy_b, we_b, busy_b, done_b, eill_b, eovf_b;
  logic [1:0]  addr_b;
  logic [31:0] data_b;
  logic [2:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_W(8)) dut_a (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_a),
    .in_valid(in_valid), .in_ready(rdy_a), .in_sel(in_sel), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .im_we(we_a), .im_addr(addr_a),
    .im_wdata(data_a), .busy(busy_a), .done(done_a), .err_illegal(eill_a),
    .err_overflow(eovf_a), .word_count(cnt_a)
  );

  mips_instr_encoder #(.ADDR_W(2)) dut_b (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_b),
    .in_valid(in_valid), .in_ready(rdy_b), .in_sel(in_sel), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .im_we(we_b), .im_addr(addr_b),
    .im_wdata(data_b), .busy(busy_b), .done(done_b), .err_illegal(eill_b),
    .err_overflow(eovf_b), .word_count(cnt_b)
  );

  typedef struct {
    logic [4:0]  sel, rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        last;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns one cycle later with the request retired.
  task automatic send(input logic [4:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last);
    in_valid = 1'b1; in_sel = sel; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt; in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] ba, input logic [1:0] bb);
    start = 1'b1; base_a = ba; base_b = bb;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; base_a = '0; base_b = '0; in_valid = 1'b0;
    in_sel = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_imm = '0; in_target = '0; in_last = 1'b0;

    //            sel    rs     rt     rd     sh     imm       tgt         last we addr   data
    vecs[0]  = '{5'd1,  5'd4,  5'd5,  5'd6,  5'd3,  16'h0000, 26'h0,      0, 1, 8'h40, 32'h00853022};
    vecs[1]  = '{5'd8,  5'd7,  5'd1,  5'd2,  5'd4,  16'h0000, 26'h0,      0, 1, 8'h41, 32'h00011100};
    vecs[2]  = '{5'd14, 5'd31, 5'd5,  5'd31, 5'd7,  16'h0000, 26'h0,      0, 1, 8'h42, 32'h03E0F809};
    vecs[3]  = '{5'd27, 5'd1,  5'd1,  5'd1,  5'd1,  16'hFFFF, 26'h0,      0, 0, 8'h42, 32'h03E0F809};
    vecs[4]  = '{5'd24, 5'd3,  5'd0,  5'd9,  5'd0,  16'hBEEF, 26'h0100000, 0, 1, 8'h43, 32'h08100000};
    vecs[5]  = '{5'd13, 5'd31, 5'd2,  5'd3,  5'd4,  16'h0000, 26'h0,      0, 1, 8'h44, 32'h03E00008};
    vecs[6]  = '{5'd20, 5'd9,  5'd10, 5'd7,  5'd6,  16'h1234, 26'h3FFFFFF, 0, 1, 8'h45, 32'h3C0A1234};
    vecs[7]  = '{5'd19, 5'd1,  5'd2,  5'd5,  5'd9,  16'hFFFE, 26'h0,      0, 1, 8'h46, 32'h1022FFFE};
    vecs[8]  = '{5'd10, 5'd5,  5'd3,  5'd4,  5'd2,  16'h0000, 26'h0,      0, 1, 8'h47, 32'h00032082};
    vecs[9]  = '{5'd25, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 0, 1, 8'h48, 32'h0FFFFFFF};
    vecs[10] = '{5'd18, 5'd29, 5'd31, 5'd3,  5'd1,  16'h0008, 26'h0,      1, 1, 8'h49, 32'hAFBF0008};

    repeat (3) @(negedge clk);
    chk("rst_we", {31'd0, we_a}, 32'd0);
    chk("rst_addr", {24'd0, addr_a}, 32'd0);
    chk("rst_data", data_a, 32'd0);
    chk("rst_flags", {26'd0, rdy_a, busy_a, done_a, eill_a, eovf_a, 1'b0}, 32'd0);
    chk("rst_cnt", {23'd0, cnt_a}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single add; a start pulse while running must not move the base.
    do_start(8'h10, 2'd0);
    chk("run_ready", {31'd0, rdy_a}, 32'd1);
    chk("run_busy", {31'd0, busy_a}, 32'd1);
    do_start(8'h70, 2'd0);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd31, 16'h0, 26'h0, 1'b1);
    chk("add_we", {31'd0, we_a}, 32'd1);
    chk("add_addr", {24'd0, addr_a}, 32'h10);
    chk("add_data", data_a, 32'h00221820);
    chk("add_done", {31'd0, done_a}, 32'd1);
    @(negedge clk);
    chk("we_pulse", {31'd0, we_a}, 32'd0);

    // addi then lw (last).
    do_start(8'h10, 2'd0);
    send(5'd15, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b0);
    chk("addi_data", data_a, 32'h20080005);
    chk("addi_addr", {24'd0, addr_a}, 32'h10);
    send(5'd17, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1);
    chk("lw_data", data_a, 32'h8FA80004);
    chk("lw_addr", {24'd0, addr_a}, 32'h11);
    chk("lw_done", {31'd0, done_a}, 32'd1);
    chk("lw_cnt", {23'd0, cnt_a}, 32'd2);
    chk("lw_ready", {31'd0, rdy_a}, 32'd0);

    // Table program at 0x40, including an illegal selector mid-stream.
    do_start(8'h40, 2'd0);
    chk("restart_cnt", {23'd0, cnt_a}, 32'd0);
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].sel, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
           vecs[i].imm, vecs[i].tgt, vecs[i].last);
      chk($sformatf("v%0d_we", i), {31'd0, we_a}, {31'd0, vecs[i].we});
      chk($sformatf("v%0d_addr", i), {24'd0, addr_a}, {24'd0, vecs[i].addr});
      chk($sformatf("v%0d_data", i), data_a, vecs[i].data);
    end
    chk("tbl_done", {31'd0, done_a}, 32'd1);
    chk("tbl_cnt", {23'd0, cnt_a}, 32'd10);
    chk("tbl_eill", {31'd0, eill_a}, 32'd1);
    chk("tbl_eovf", {31'd0, eovf_a}, 32'd0);

    // Overflow on the 4-word instance: base 3 wraps through 0, 1, 2.
    do_start(8'h00, 2'd3);
    chk("ovf_eill_clr", {31'd0, eill_b}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      send(5'd0, 5'd1, 5'd2, 5'(i), 5'd0, 16'h0, 26'h0, 1'b0);
      chk($sformatf("ovf%0d_we", i), {31'd0, we_b}, 32'd1);
      chk($sformatf("ovf%0d_addr", i), {30'd0, addr_b}, 32'((3 + i) % 4));
      chk($sformatf("ovf%0d_data", i), data_b, 32'h00220020 | (32'(i) << 11));
    end
    chk("ovf_done", {31'd0, done_b}, 32'd1);
    chk("ovf_flag", {31'd0, eovf_b}, 32'd1);
    chk("ovf_ready", {31'd0, rdy_b}, 32'd0);
    chk("ovf_cnt", {29'd0, cnt_b}, 32'd4);
    chk("ovf_a_busy", {31'd0, busy_a}, 32'd1);

    // Reset lands right after an accepting edge: the pending write is dropped.
    in_valid = 1'b1; in_sel = 5'd0; in_rs = 5'd1; in_rt = 5'd1; in_rd = 5'd1;
    @(posedge clk);
    #1 rstn = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("arst_we", {31'd0, we_a}, 32'd0);
    chk("arst_out", {data_a[31:1], busy_a}, 32'd0);
    chk("arst_addr", {23'd0, addr_a, done_a}, 32'd0);
    chk("arst_cnt", {21'd0, cnt_a, eill_a, eovf_a}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("arst_ready", {31'd0, rdy_a}, 32'd0);
    do_start(8'h20, 2'd0);
    send(5'd6, 5'd2, 5'd3, 5'd4, 5'd0, 16'h0, 26'h0, 1'b1);
    chk("post_we", {31'd0, we_a}, 32'd1);
    chk("post_addr", {24'd0, addr_a}, 32'h20);
    chk("post_data", data_a, 32'h00432021);
    chk("post_cnt", {23'd0, cnt_a}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
